// File: rtl/plsgen_mc.sv
// Multi-channel edge-qualified pulse generator: each channel synchronizes an async level,
// debounces it, qualifies rise/fall edges by mode, stretches a pulse and keeps a sticky flag.

module plsgen_mc_ch #(
    parameter int SYNC_STG = 2,
    parameter int FLT_LEN  = 4,
    parameter int PLS_W    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_d,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_lvl,
    output logic       o_pls,
    output logic       o_sts
);
    localparam int FW = $clog2(FLT_LEN) + 1;
    localparam int PW = $clog2(PLS_W + 1);
    localparam logic [FW-1:0] FMAX = FW'(FLT_LEN - 1);
    localparam logic [PW-1:0] PMAX = PW'(PLS_W);
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [SYNC_STG-1:0] r_sync;
    logic [FW-1:0]       r_fcnt;
    logic [PW-1:0]       r_pcnt;
    logic                r_lvl;
    logic                r_pls;
    logic                r_sts;

    logic w_s;
    logic w_acc;
    logic w_evt;

    assign w_s   = r_sync[SYNC_STG-1];
    // Accept only once the mismatch has persisted for FLT_LEN consecutive samples.
    assign w_acc = (w_s != r_lvl) && (r_fcnt == FMAX);
    // Mode bit 0 qualifies rising edges, bit 1 falling edges.
    assign w_evt = w_acc && (w_s ? i_mode[0] : i_mode[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_fcnt <= '0;
            r_lvl  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_d};
            if (w_s == r_lvl) begin
                r_fcnt <= '0;
            end else if (w_acc) begin
                r_lvl  <= w_s;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Pulse stretcher: a new event reloads the count, so overlapping events merge into one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_pls  <= 1'b0;
        end else if (w_evt) begin
            r_pcnt <= PMAX;
            r_pls  <= 1'b1;
        end else if (r_pcnt != '0) begin
            r_pcnt <= r_pcnt - 1'b1;
            r_pls  <= (r_pcnt != PONE);
        end
    end

    // Set has priority over clear so an event coinciding with clr is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sts <= 1'b0;
        else     r_sts <= w_evt | (r_sts & ~i_clr);
    end

    assign o_lvl = r_lvl;
    assign o_pls = r_pls;
    assign o_sts = r_sts;
endmodule

module plsgen_mc #(
    parameter int CH       = 4,
    parameter int SYNC_STG = 2,
    parameter int FLT_LEN  = 4,
    parameter int PLS_W    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] d,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] lvl,
    output logic [CH-1:0] pls,
    output logic [CH-1:0] sts,
    output logic          irq
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        plsgen_mc_ch #(
            .SYNC_STG (SYNC_STG),
            .FLT_LEN  (FLT_LEN),
            .PLS_W    (PLS_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_d    (d[i]),
            .i_mode (mode[2*i+1:2*i]),
            .i_clr  (clr[i]),
            .o_lvl  (lvl[i]),
            .o_pls  (pls[i]),
            .o_sts  (sts[i])
        );
    end

    assign irq = |sts;
endmodule

// File: tb/tb_plsgen_mc.sv
// Directed bench for plsgen_mc: a per-cycle vector table on the default configuration plus
// hand sequences for pulse stretching, mode change mid-pulse and reset mid-pulse.

module tb_plsgen_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: default config (FLT_LEN=4, PLS_W=1)
    logic       rst_a;
    logic [3:0] d_a, clr_a, lvl_a, pls_a, sts_a;
    logic [7:0] mode_a;
    logic       irq_a;
    // DUT B: FLT_LEN=1, PLS_W=5
    logic       rst_b;
    logic [3:0] d_b, clr_b, lvl_b, pls_b, sts_b;
    logic [7:0] mode_b;
    logic       irq_b;
    // DUT C: FLT_LEN=4, PLS_W=8
    logic       rst_c;
    logic [3:0] d_c, clr_c, lvl_c, pls_c, sts_c;
    logic [7:0] mode_c;
    logic       irq_c;

    plsgen_mc #(.CH(4), .SYNC_STG(2), .FLT_LEN(4), .PLS_W(1)) u_a (
        .clk(clk), .rst(rst_a), .d(d_a), .mode(mode_a), .clr(clr_a),
        .lvl(lvl_a), .pls(pls_a), .sts(sts_a), .irq(irq_a));
    plsgen_mc #(.CH(4), .SYNC_STG(2), .FLT_LEN(1), .PLS_W(5)) u_b (
        .clk(clk), .rst(rst_b), .d(d_b), .mode(mode_b), .clr(clr_b),
        .lvl(lvl_b), .pls(pls_b), .sts(sts_b), .irq(irq_b));
    plsgen_mc #(.CH(4), .SYNC_STG(2), .FLT_LEN(4), .PLS_W(8)) u_c (
        .clk(clk), .rst(rst_c), .d(d_c), .mode(mode_c), .clr(clr_c),
        .lvl(lvl_c), .pls(pls_c), .sts(sts_c), .irq(irq_c));

    typedef struct {
        logic [3:0] d;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] pls;
        logic [3:0] sts;
        logic       irq;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] d, input logic [3:0] c, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] s, input logic q, input int rep);
        vec_t v;
        v.d = d; v.clr = c; v.lvl = l; v.pls = p; v.sts = s; v.irq = q;
        for (int k = 0; k < rep; k++) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int first, last, cnt, rises;
    logic prev, seen;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        d_a = '0; d_b = '0; d_c = '0;
        clr_a = '0; clr_b = '0; clr_c = '0;
        mode_a = 8'b11_10_00_01;
        mode_b = 8'b00_10_11_00;
        mode_c = 8'b00_00_00_01;
        tick(); tick();
        chk("rst_lvl", {28'd0, lvl_a}, 32'd0);
        chk("rst_pls", {28'd0, pls_a}, 32'd0);
        chk("rst_sts", {28'd0, sts_a}, 32'd0);
        chk("rst_irq", {31'd0, irq_a}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ch0 rise (rise-only): event after edge 6, one-cycle pulse, then clear
        add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5);
        add(4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 1);
        add(4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 1);
        add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1);
        // ch3 3-cycle glitch is filtered out
        add(4'h9, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 3);
        add(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4);
        // ch0 fall with rise-only mode: level follows, no pulse
        add(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 5);
        add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1);
        // ch1 mode off: level tracks, no pulse
        add(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5);
        add(4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 1);
        // ch3 rise with clr on the event cycle: set wins, then clr alone clears
        add(4'hA, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0, 5);
        add(4'hA, 4'h8, 4'hA, 4'h8, 4'h8, 1'b1, 1);
        add(4'hA, 4'h8, 4'hA, 4'h0, 4'h0, 1'b0, 1);

        foreach (tbl[i]) begin
            d_a = tbl[i].d; clr_a = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_lvl", i), {28'd0, lvl_a}, {28'd0, tbl[i].lvl});
            chk($sformatf("tbl%0d_pls", i), {28'd0, pls_a}, {28'd0, tbl[i].pls});
            chk($sformatf("tbl%0d_sts", i), {28'd0, sts_a}, {28'd0, tbl[i].sts});
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq_a}, {31'd0, tbl[i].irq});
        end
        clr_a = '0;

        // B: ch1 both edges, rise then fall 3 cycles later -> one 8-cycle pulse
        first = 0; last = 0; cnt = 0;
        d_b[1] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 4) d_b[1] = 1'b0;
            tick();
            if (pls_b[1]) begin
                cnt++;
                if (first == 0) first = e;
                last = e;
            end
        end
        chk("b1_first", first, 3);
        chk("b1_count", cnt, 8);
        chk("b1_nogap", last - first + 1, 8);
        chk("b1_lvl", {31'd0, lvl_b[1]}, 32'd0);
        chk("b1_sts", {31'd0, sts_b[1]}, 32'd1);

        // B: ch2 fall-only; rise gives no pulse, fall pulse survives mode change to off
        seen = 1'b0;
        d_b[2] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            seen = seen | pls_b[2];
        end
        chk("b2_rise_nopls", {31'd0, seen}, 32'd0);
        chk("b2_rise_lvl", {31'd0, lvl_b[2]}, 32'd1);
        chk("b2_rise_sts", {31'd0, sts_b[2]}, 32'd0);
        first = 0; last = 0; cnt = 0;
        d_b[2] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (pls_b[2]) begin
                cnt++;
                if (first == 0) first = e;
                last = e;
            end
            if (cnt == 2) mode_b[5:4] = 2'b00;
        end
        chk("b2_first", first, 3);
        chk("b2_count", cnt, 5);
        chk("b2_nogap", last - first + 1, 5);
        chk("b2_sts", {28'd0, sts_b}, 32'h6);
        chk("b2_irq", {31'd0, irq_b}, 32'd1);

        // C: reset mid-pulse, d held high through release -> exactly one new pulse
        first = 0;
        d_c[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (pls_c[0] && first == 0) first = e;
        end
        chk("c_first", first, 6);
        chk("c_pls_before", {31'd0, pls_c[0]}, 32'd1);
        rst_c = 1'b1;
        #2;
        chk("c_rst_pls", {28'd0, pls_c}, 32'd0);
        chk("c_rst_lvl", {28'd0, lvl_c}, 32'd0);
        chk("c_rst_sts", {28'd0, sts_c}, 32'd0);
        chk("c_rst_irq", {31'd0, irq_c}, 32'd0);
        tick();
        rst_c = 1'b0;
        first = 0; cnt = 0; rises = 0; prev = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (pls_c[0]) begin
                cnt++;
                if (first == 0) first = e;
            end
            if (pls_c[0] && !prev) rises++;
            prev = pls_c[0];
        end
        chk("c_rel_first", first, 6);
        chk("c_rel_count", cnt, 8);
        chk("c_rel_rises", rises, 1);
        chk("c_rel_sts", {31'd0, sts_c[0]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
